// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Lets two requesters share the single-port data memory: port 0 (pipeline MEM stage)
//   and port 1 (loader/DMA). The winning request is latched, presented to the memory
//   for one cycle (ACCESS), and completed with a one-cycle response pulse (RESP). A new
//   request can be accepted during RESP, so back-to-back accesses take 2 cycles each.
// Ports
//   clock, reset_n           clock, asynchronous active-low reset
//   pN_valid/write/addr/wdata request from port N (N = 0, 1)
//   pN_ready                 request accepted this cycle (combinational)
//   pN_resp, pN_err          completion pulse; err flags a misaligned (not performed) access
//   resp_rdata               load data for the responding port, 0 for stores/errors
//   stall                    hold the pipeline while port 0 is waiting or in flight
//   mem_read/mem_write/mem_address/mem_wdata/mem_rdata   data_memory interface
module dmem_port_arbiter #(
  parameter int unsigned RR_MODE  = 1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_valid,
  input  logic        p0_write,
  input  logic [63:0] p0_addr,
  input  logic [63:0] p0_wdata,
  output logic        p0_ready,
  output logic        p0_resp,
  output logic        p0_err,
  input  logic        p1_valid,
  input  logic        p1_write,
  input  logic [63:0] p1_addr,
  input  logic [63:0] p1_wdata,
  output logic        p1_ready,
  output logic        p1_resp,
  output logic        p1_err,
  output logic [63:0] resp_rdata,
  output logic        stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              port_q, port_d;     // 0 = port 0, 1 = port 1
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              prio_q, prio_d;     // port preferred when both request (round-robin)
  logic [WaitW-1:0]  wait_q, wait_d;

  logic grant;   // 1 = port 1 wins
  logic accept;

  always_comb begin
    if (RR_MODE != 0) begin
      grant = (p0_valid & p1_valid) ? prio_q : p1_valid;
    end else begin
      grant = p1_valid & (~p0_valid | (wait_q == WaitMax));
    end
    accept   = ((state_q == StIdle) || (state_q == StResp)) & (p0_valid | p1_valid);
    p0_ready = accept & ~grant;
    p1_ready = accept & grant;
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    write_d = write_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    prio_d  = prio_q;
    wait_d  = wait_q;

    unique case (state_q)
      StIdle:   if (accept) state_d = StAccess;
      StAccess: begin
        state_d = StResp;
        rdata_d = (~write_q & ~err_q) ? mem_rdata : '0;
      end
      StResp:   state_d = accept ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase

    if (accept) begin
      port_d  = grant;
      write_d = grant ? p1_write : p0_write;
      addr_d  = grant ? p1_addr : p0_addr;
      wdata_d = grant ? p1_wdata : p0_wdata;
      err_d   = grant ? (p1_addr[2:0] != 3'b000) : (p0_addr[2:0] != 3'b000);
      prio_d  = ~grant;
    end

    // Starvation counter for port 1; counts every cycle it waits, in any state.
    if (p1_ready) begin
      wait_d = '0;
    end else if (p1_valid && (wait_q != WaitMax)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      prio_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      prio_q  <= prio_d;
      wait_q  <= wait_d;
    end
  end

  // Memory strobes derive from state_q only, so an async reset drops them at once.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    if (state_q == StAccess) begin
      mem_read    = ~write_q & ~err_q;
      mem_write   = write_q & ~err_q;
      mem_address = addr_q;
      mem_wdata   = wdata_q;
    end
  end

  always_comb begin
    p0_resp    = (state_q == StResp) & ~port_q;
    p1_resp    = (state_q == StResp) & port_q;
    p0_err     = p0_resp & err_q;
    p1_err     = p1_resp & err_q;
    resp_rdata = (state_q == StResp) ? rdata_q : '0;
    stall      = p0_valid | ((state_q != StIdle) & ~port_q);
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clock;
  logic        reset_n;
  logic        p0_valid, p0_write, p1_valid, p1_write;
  logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  // Round-robin instance
  logic        rr_p0_ready, rr_p0_resp, rr_p0_err, rr_p1_ready, rr_p1_resp, rr_p1_err;
  logic [63:0] rr_resp_rdata, rr_mem_address, rr_mem_wdata, rr_mem_rdata;
  logic        rr_stall, rr_mem_read, rr_mem_write;
  // Fixed-priority instance, MAX_WAIT = 3
  logic        fp_p0_ready, fp_p0_resp, fp_p0_err, fp_p1_ready, fp_p1_resp, fp_p1_err;
  logic [63:0] fp_resp_rdata, fp_mem_address, fp_mem_wdata, fp_mem_rdata;
  logic        fp_stall, fp_mem_read, fp_mem_write;

  logic [63:0] mem_rr [32];
  logic [63:0] mem_fp [32];

  int n_checks = 0;
  int n_fail   = 0;
  int n_reads  = 0;

  dmem_port_arbiter #(.RR_MODE(1), .MAX_WAIT(8)) u_rr (
    .clock(clock), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(rr_p0_ready), .p0_resp(rr_p0_resp), .p0_err(rr_p0_err),
    .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(rr_p1_ready), .p1_resp(rr_p1_resp), .p1_err(rr_p1_err),
    .resp_rdata(rr_resp_rdata), .stall(rr_stall),
    .mem_read(rr_mem_read), .mem_write(rr_mem_write), .mem_address(rr_mem_address),
    .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata)
  );

  dmem_port_arbiter #(.RR_MODE(0), .MAX_WAIT(3)) u_fp (
    .clock(clock), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(fp_p0_ready), .p0_resp(fp_p0_resp), .p0_err(fp_p0_err),
    .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(fp_p1_ready), .p1_resp(fp_p1_resp), .p1_err(fp_p1_err),
    .resp_rdata(fp_resp_rdata), .stall(fp_stall),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_address(fp_mem_address),
    .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple data memories, combinational read, indexed by doubleword
  assign rr_mem_rdata = mem_rr[rr_mem_address[7:3]];
  assign fp_mem_rdata = mem_fp[fp_mem_address[7:3]];
  always @(posedge clock) begin
    if (rr_mem_write) mem_rr[rr_mem_address[7:3]] <= rr_mem_wdata;
    if (fp_mem_write) mem_fp[fp_mem_address[7:3]] <= fp_mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       exp_g [4];
    logic [1:0] prev;
    for (int i = 0; i < 32; i++) begin
      mem_rr[i] = '0;
      mem_fp[i] = '0;
    end
    reset_n  = 1'b0;
    p0_valid = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;

    // Reset state
    @(negedge clock); #1;
    chk("rst_mem_read", 64'(rr_mem_read), 64'd0);
    chk("rst_mem_write", 64'(rr_mem_write), 64'd0);
    chk("rst_p0_ready", 64'(rr_p0_ready), 64'd0);
    chk("rst_stall", 64'(rr_stall), 64'd0);
    chk("rst_rdata", rr_resp_rdata, 64'd0);
    chk("rst_p1_resp", 64'(rr_p1_resp), 64'd0);
    @(negedge clock); reset_n = 1'b1;

    // T1: store then load at 0x10
    @(negedge clock);
    p0_valid = 1'b1; p0_write = 1'b1; p0_addr = 64'h10; p0_wdata = 64'hDEAD_BEEF; #1;
    chk("t1_st_ready", 64'(rr_p0_ready), 64'd1);
    chk("t1_st_stall", 64'(rr_stall), 64'd1);
    @(negedge clock); p0_valid = 1'b0; #1;
    chk("t1_st_mem_write", 64'(rr_mem_write), 64'd1);
    chk("t1_st_mem_read", 64'(rr_mem_read), 64'd0);
    chk("t1_st_addr", rr_mem_address, 64'h10);
    chk("t1_st_wdata", rr_mem_wdata, 64'hDEAD_BEEF);
    chk("t1_st_stall_acc", 64'(rr_stall), 64'd1);
    @(negedge clock); p0_valid = 1'b1; p0_write = 1'b0; #1;
    chk("t1_st_resp", 64'(rr_p0_resp), 64'd1);
    chk("t1_st_err", 64'(rr_p0_err), 64'd0);
    chk("t1_st_rdata", rr_resp_rdata, 64'd0);
    chk("t1_ld_ready", 64'(rr_p0_ready), 64'd1);
    @(negedge clock); p0_valid = 1'b0; #1;
    chk("t1_ld_mem_read", 64'(rr_mem_read), 64'd1);
    chk("t1_ld_mem_write", 64'(rr_mem_write), 64'd0);
    @(negedge clock); #1;
    chk("t1_ld_resp", 64'(rr_p0_resp), 64'd1);
    chk("t1_ld_rdata", rr_resp_rdata, 64'hDEAD_BEEF);
    chk("t1_ld_stall", 64'(rr_stall), 64'd1);
    @(negedge clock); #1;
    chk("t1_idle_resp", 64'(rr_p0_resp), 64'd0);
    chk("t1_idle_stall", 64'(rr_stall), 64'd0);

    // T4: misaligned p1 load
    @(negedge clock); p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 64'h13; #1;
    chk("t4_ready", 64'(rr_p1_ready), 64'd1);
    @(negedge clock); p1_valid = 1'b0; #1;
    chk("t4_mem_read", 64'(rr_mem_read), 64'd0);
    chk("t4_mem_write", 64'(rr_mem_write), 64'd0);
    @(negedge clock); #1;
    chk("t4_resp", 64'(rr_p1_resp), 64'd1);
    chk("t4_err", 64'(rr_p1_err), 64'd1);
    chk("t4_rdata", rr_resp_rdata, 64'd0);
    chk("t4_p0_resp", 64'(rr_p0_resp), 64'd0);

    // T2: round-robin, both ports valid every cycle -> grants 0,1,0,1
    @(negedge clock);
    p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 64'h10;
    p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 64'h18;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      if (i % 2 == 0) begin
        chk($sformatf("t2_p0_ready_%0d", i), 64'(rr_p0_ready), 64'((i / 2) % 2 == 0));
        chk($sformatf("t2_p1_ready_%0d", i), 64'(rr_p1_ready), 64'((i / 2) % 2 == 1));
      end else begin
        chk($sformatf("t2_busy_%0d", i), 64'(rr_p0_ready | rr_p1_ready), 64'd0);
      end
      if (i >= 2 && i % 2 == 0) begin
        prev = 2'(((i / 2) - 1) % 2);
        chk($sformatf("t2_p0_resp_%0d", i), 64'(rr_p0_resp), 64'(prev == 2'd0));
        chk($sformatf("t2_p1_resp_%0d", i), 64'(rr_p1_resp), 64'(prev == 2'd1));
        chk($sformatf("t2_rdata_%0d", i), rr_resp_rdata,
            (prev == 2'd0) ? 64'hDEAD_BEEF : 64'd0);
      end
    end
    @(negedge clock); p0_valid = 1'b0; p1_valid = 1'b0; reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;

    // T3: fixed priority, MAX_WAIT = 3 -> p0, p0, p1, p0
    exp_g = '{1'b0, 1'b0, 1'b1, 1'b0};
    p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 64'h10;
    p1_valid = 1'b1; p1_write = 1'b0; p1_addr = 64'h20;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      if (i % 2 == 0) begin
        chk($sformatf("t3_p0_ready_%0d", i), 64'(fp_p0_ready), 64'(!exp_g[i / 2]));
        chk($sformatf("t3_p1_ready_%0d", i), 64'(fp_p1_ready), 64'(exp_g[i / 2]));
      end
    end
    chk("t3_p1_resp", 64'(fp_p1_resp), 64'd1);
    chk("t3_p1_err", 64'(fp_p1_err), 64'd0);
    @(negedge clock); p0_valid = 1'b0; p1_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // T5: reset during ACCESS of a p0 store
    p0_valid = 1'b1; p0_write = 1'b1; p0_addr = 64'h28; p0_wdata = 64'h1234; #1;
    chk("t5_ready", 64'(rr_p0_ready), 64'd1);
    @(negedge clock); p0_valid = 1'b0; #1;
    chk("t5_mem_write_pre", 64'(rr_mem_write), 64'd1);
    #1 reset_n = 1'b0; #1;
    chk("t5_mem_write_async", 64'(rr_mem_write), 64'd0);
    chk("t5_mem_addr_async", rr_mem_address, 64'd0);
    @(negedge clock); #1;
    chk("t5_no_resp", 64'(rr_p0_resp), 64'd0);
    chk("t5_mem_untouched", mem_rr[5], 64'd0);
    @(negedge clock); reset_n = 1'b1; #1;
    chk("t5_no_resp2", 64'(rr_p0_resp), 64'd0);
    chk("t5_stall", 64'(rr_stall), 64'd0);

    // T6: five back-to-back p0 loads
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      p0_valid = (i <= 8); p0_write = 1'b0; p0_addr = 64'h10; #1;
      if (rr_mem_read) n_reads++;
      chk($sformatf("t6_mem_read_%0d", i), 64'(rr_mem_read), 64'(i % 2 == 1));
      chk($sformatf("t6_stall_%0d", i), 64'(rr_stall), 64'd1);
      chk($sformatf("t6_resp_%0d", i), 64'(rr_p0_resp), 64'(i >= 2 && i % 2 == 0));
      if (i <= 8) chk($sformatf("t6_ready_%0d", i), 64'(rr_p0_ready), 64'(i % 2 == 0));
      if (i >= 2 && i % 2 == 0) chk($sformatf("t6_rdata_%0d", i), rr_resp_rdata, 64'hDEAD_BEEF);
    end
    chk("t6_read_count", 64'(n_reads), 64'd5);
    @(negedge clock); #1;
    chk("t6_idle_stall", 64'(rr_stall), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
